// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults and width helper for the multi-channel clock divider
//
// Purpose : default constants for clk_div_multi / clk_div_ch and the
//           channel-select width function.
// Contents: NUM_CH_DEF, CNT_W_DEF, DEF_DIV_DEF, ch_width().

package clk_div_pkg;

  // Number of divider channels (legal range 1..16).
  localparam int NUM_CH_DEF  = 4;
  // Counter / divide-value width.
  localparam int CNT_W_DEF   = 27;
  // Reset terminal count: 1 Hz clk_out from a 100 MHz clk_in.
  localparam int DEF_DIV_DEF = 49_999_999;

  // Width of the channel select field. A single channel still gets one bit,
  // so a write to "channel 1" is representable and can be rejected.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one independent divider channel with shadowed divide value
//
// Purpose : counts clk_in cycles up to act_div, emits a one-cycle tick at
//           each terminal count and toggles clk_out. A new divide value is
//           held in a shadow register and only takes effect at a terminal
//           count (or at once while the channel is disabled), so a running
//           period is never cut short.
// Optional: CLK_DIV_DUTY_EN adds a shadowed duty compare and pwm_out.
//
// Ports   :
//   clk_in      in   divider clock
//   rst         in   asynchronous active-high reset (already deassert-synchronised)
//   en          in   run enable; low holds counter and outputs at 0
//   wr          in   one-cycle write strobe for this channel
//   wr_div      in   CNT_W new terminal count
//   wr_duty     in   CNT_W new duty compare (CLK_DIV_DUTY_EN only)
//   tick        out  one-cycle pulse after each terminal count
//   clk_out     out  divided clock, toggles with each tick
//   cfg_pending out  shadow value waiting to be applied
//   pwm_out     out  high while count < act_duty (CLK_DIV_DUTY_EN only)

module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W-1:0] wr_duty,
  output logic             pwm_out,
`endif
  output logic             tick,
  output logic             clk_out,
  output logic             cfg_pending
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] shd_div;

  logic term;      // this cycle is the terminal count of a running channel
  logic take_wr;   // write coincides with terminal count: apply write data directly
  logic take_shd;  // apply the shadow (terminal count, or channel idle)

  always_comb begin
    term     = en && (count == act_div);
    take_wr  = term && wr;
    take_shd = (term || !en) && cfg_pending && !take_wr;
  end

  // Divide-value shadowing. A write landing on the terminal count is applied
  // right there and never shows as pending. When the shadow is applied while
  // a new write arrives on an idle channel, that write stays pending and is
  // applied on the following cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      act_div     <= RST_DIV;
      shd_div     <= RST_DIV;
      cfg_pending <= 1'b0;
    end else begin
      if (wr) begin
        shd_div <= wr_div;
      end
      if (take_wr) begin
        act_div     <= wr_div;
        cfg_pending <= 1'b0;
      end else if (take_shd) begin
        act_div     <= shd_div;
        cfg_pending <= wr;
      end else if (wr) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  // Counter and outputs. With act_div == 0 every cycle is a terminal count,
  // so tick stays high and clk_out toggles every cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count   <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (!en) begin
      count   <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (term) begin
      count   <= '0;
      tick    <= 1'b1;
      clk_out <= ~clk_out;
    end else begin
      count   <= count + 1'b1;
      tick    <= 1'b0;
    end
  end

`ifdef CLK_DIV_DUTY_EN
  localparam logic [CNT_W-1:0] RST_DUTY = CNT_W'((DEF_DIV + 1) / 2);

  logic [CNT_W-1:0] act_duty;
  logic [CNT_W-1:0] shd_duty;

  // Duty compare follows exactly the same apply points as the divide value.
  // act_duty > act_div keeps pwm_out high; act_duty == 0 keeps it low.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      act_duty <= RST_DUTY;
      shd_duty <= RST_DUTY;
      pwm_out  <= 1'b0;
    end else begin
      if (wr) begin
        shd_duty <= wr_duty;
      end
      if (take_wr) begin
        act_duty <= wr_duty;
      end else if (take_shd) begin
        act_duty <= shd_duty;
      end
      pwm_out <= en && (count < act_duty);
    end
  end
`endif

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider top level
//
// Purpose : reset-deassertion synchroniser and configuration write decode
//           around NUM_CH clk_div_ch channels.
// Optional: define CLK_DIV_DUTY_EN to add cfg_duty / pwm_out.
//
// Ports   :
//   clk_in      in   sole clock, 100 MHz nominal
//   rst         in   asynchronous active-high reset
//   ch_en       in   NUM_CH per-channel run enable
//   cfg_wr      in   one-cycle write strobe
//   cfg_ch      in   CH_W target channel (out-of-range writes are dropped)
//   cfg_div     in   CNT_W new terminal count
//   cfg_duty    in   CNT_W new duty compare (CLK_DIV_DUTY_EN only)
//   tick        out  NUM_CH one-cycle terminal-count pulses
//   clk_out     out  NUM_CH divided clocks
//   cfg_pending out  NUM_CH shadow value waiting per channel
//   pwm_out     out  NUM_CH duty outputs (CLK_DIV_DUTY_EN only)

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic                          cfg_wr,
  input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W-1:0]              cfg_duty,
  output logic [NUM_CH-1:0]             pwm_out,
`endif
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             clk_out,
  output logic [NUM_CH-1:0]             cfg_pending
);

  // Reset asserts everywhere immediately; release is retimed through two
  // flops so every channel leaves reset on the same clk_in edge.
  logic rst_meta;
  logic rst_sync;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  // One-hot write decode; a cfg_ch beyond the last channel matches nothing.
  logic [NUM_CH-1:0] ch_wr;

  always_comb begin
    ch_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_wr && (int'(cfg_ch) == i)) begin
        ch_wr[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_in      (clk_in),
      .rst         (rst_sync),
      .en          (ch_en[g]),
      .wr          (ch_wr[g]),
      .wr_div      (cfg_div),
`ifdef CLK_DIV_DUTY_EN
      .wr_duty     (cfg_duty),
      .pwm_out     (pwm_out[g]),
`endif
      .tick        (tick[g]),
      .clk_out     (clk_out[g]),
      .cfg_pending (cfg_pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - table-driven self-checking bench for clk_div_multi (NUM_CH=4, CNT_W=8, DEF_DIV=3)

module tb_clk_div_multi;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [3:0] ch_en;
  logic       cfg_wr;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] tick, clk_out, cfg_pending;

  // Second instance with five channels: cfg_ch is 3 bits wide, so writes to
  // channel 5 and 7 are genuinely out of range.
  logic [4:0] ch_en5;
  logic       cfg_wr5;
  logic [2:0] cfg_ch5;
  logic [7:0] cfg_div5;
  logic [4:0] tick5, clk5, pend5;

`ifdef CLK_DIV_DUTY_EN
  logic [7:0] cfg_duty;
  logic [3:0] pwm_out;
  logic [7:0] cfg_duty5;
  logic [4:0] pwm5;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  clk_div_multi #(.NUM_CH(4), .CNT_W(8), .DEF_DIV(3)) u_dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .ch_en       (ch_en),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
`ifdef CLK_DIV_DUTY_EN
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
`endif
    .tick        (tick),
    .clk_out     (clk_out),
    .cfg_pending (cfg_pending)
  );

  clk_div_multi #(.NUM_CH(5), .CNT_W(8), .DEF_DIV(3)) u_dut5 (
    .clk_in      (clk_in),
    .rst         (rst),
    .ch_en       (ch_en5),
    .cfg_wr      (cfg_wr5),
    .cfg_ch      (cfg_ch5),
    .cfg_div     (cfg_div5),
`ifdef CLK_DIV_DUTY_EN
    .cfg_duty    (cfg_duty5),
    .pwm_out     (pwm5),
`endif
    .tick        (tick5),
    .clk_out     (clk5),
    .cfg_pending (pend5)
  );

  typedef struct {
    logic       wr;
    logic [1:0] ch;
    logic [7:0] div;
    logic [3:0] en;
    logic [3:0] exp_tick;
    logic [3:0] exp_pend;
    logic [3:0] clk_mask;
    logic [3:0] exp_clk;
  } vec_t;

  vec_t       vecs [1:40];
  logic [3:0] tick_tab [40];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input int b, input int budget, output int found);
    found = 0;
    for (int n = 0; n < budget && found == 0; n++) begin
      step();
      if (tick[b]) found = 1;
    end
  endtask

  initial begin
    int         found;
    logic [3:0] prev_clk;
    logic [4:0] exp5;

    // Expected tick per row, relative to the first tick after reset (row 0).
    tick_tab = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF,   // 1-8
                 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h4, 4'h0, 4'hF,   // 9-16
                 4'h0, 4'h4, 4'h0, 4'hF, 4'h1, 4'h5, 4'h1, 4'hF,   // 17-24
                 4'h1, 4'h5, 4'h3, 4'hD, 4'h1, 4'h7, 4'h1, 4'h5,   // 25-32
                 4'h3, 4'h5, 4'h1, 4'hF, 4'h1, 4'h5, 4'h3, 4'hD};  // 33-40
    for (int k = 1; k <= 40; k++) begin
      vecs[k].wr       = 1'b0;
      vecs[k].ch       = 2'd0;
      vecs[k].div      = 8'd0;
      vecs[k].en       = 4'hF;
      vecs[k].exp_tick = tick_tab[k-1];
      vecs[k].exp_pend = 4'h0;
      vecs[k].clk_mask = 4'h0;
      vecs[k].exp_clk  = 4'h0;
    end
    for (int k = 1; k <= 8; k++) begin
      vecs[k].clk_mask = 4'hF;
      vecs[k].exp_clk  = (k < 4 || k == 8) ? 4'hF : 4'h0;
    end
    // ch2 -> div 1 mid-period: pending until the period ends at row 12
    vecs[9].wr  = 1'b1; vecs[9].ch  = 2'd2; vecs[9].div  = 8'd1;
    vecs[10].exp_pend = 4'h4; vecs[11].exp_pend = 4'h4;
    // ch0 -> div 0 on its terminal count: never pending, tick stuck high
    vecs[19].wr = 1'b1; vecs[19].ch = 2'd0; vecs[19].div = 8'd0;
    // ch1 -> 7 then 2 while pending: 2 wins, period 3 from row 24
    vecs[21].wr = 1'b1; vecs[21].ch = 2'd1; vecs[21].div = 8'd7;
    vecs[22].wr = 1'b1; vecs[22].ch = 2'd1; vecs[22].div = 8'd2;
    vecs[22].exp_pend = 4'h2; vecs[23].exp_pend = 4'h2;
    // ch3 disabled for three rows, re-enabled at row 32 -> tick at row 36
    vecs[29].en = 4'h7; vecs[30].en = 4'h7; vecs[31].en = 4'h7;
    vecs[30].clk_mask = 4'h8; vecs[31].clk_mask = 4'h8; vecs[32].clk_mask = 4'h8;
    vecs[36].clk_mask = 4'h8; vecs[36].exp_clk = 4'h8;

    rst = 1'b1; ch_en = 4'hF; cfg_wr = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
    ch_en5 = 5'h1F; cfg_wr5 = 1'b0; cfg_ch5 = 3'd0; cfg_div5 = 8'd0;
`ifdef CLK_DIV_DUTY_EN
    cfg_duty = 8'd2; cfg_duty5 = 8'd2;
`endif
    repeat (3) step();
    chk("reset tick", tick, 4'h0);
    chk("reset clk_out", clk_out, 4'h0);
    chk("reset pending", cfg_pending, 4'h0);
`ifdef CLK_DIV_DUTY_EN
    chk("reset pwm", pwm_out, 4'h0);
`endif
    rst = 1'b0;

    wait_tick(0, 20, found);
    chk("first tick found", found, 1);
    chk("first tick all channels", tick, 4'hF);
    chk("first tick clk_out", clk_out, 4'hF);
    chk("dut5 first tick", tick5, 5'h1F);
    prev_clk = clk_out;

    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("tick row %0d", k), tick, vecs[k].exp_tick);
      chk($sformatf("pending row %0d", k), cfg_pending, vecs[k].exp_pend);
      if (vecs[k].clk_mask != 4'h0)
        chk($sformatf("clk_out row %0d", k), clk_out & vecs[k].clk_mask, vecs[k].exp_clk);
      chk($sformatf("clk_out toggle row %0d", k), clk_out[2:0], prev_clk[2:0] ^ tick[2:0]);
      prev_clk = clk_out;
      if (k <= 16) begin
        exp5 = (k % 4 == 0) ? 5'h1F : 5'h00;
        chk($sformatf("dut5 tick row %0d", k), tick5, exp5);
        chk($sformatf("dut5 pending row %0d", k), pend5, 5'h00);
        if (k <= 8)
          chk($sformatf("dut5 clk_out row %0d", k), clk5, (k < 4 || k == 8) ? 5'h1F : 5'h00);
      end
      cfg_wr  = vecs[k].wr;
      cfg_ch  = vecs[k].ch;
      cfg_div = vecs[k].div;
      ch_en   = vecs[k].en;
      cfg_wr5 = (k == 2 || k == 6);
      cfg_ch5 = (k == 2) ? 3'd5 : 3'd7;
      cfg_div5 = 8'd1;
    end
    cfg_wr = 1'b0; cfg_wr5 = 1'b0;

`ifdef CLK_DIV_DUTY_EN
    // duty 1 of div 3: pwm high one cycle in four, the cycle after each tick
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd3; cfg_duty = 8'd1;
    step(); cfg_wr = 1'b0;
    wait_tick(3, 10, found);
    chk("duty1 tick found", found, 1);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk($sformatf("pwm duty1 cycle %0d", j), pwm_out[3], (j % 4 == 1) ? 1 : 0);
    end
    // duty above the divide value: constant high
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd3; cfg_duty = 8'd9;
    step(); cfg_wr = 1'b0;
    wait_tick(3, 10, found);
    chk("duty9 tick found", found, 1);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk($sformatf("pwm duty9 cycle %0d", j), pwm_out[3], 1);
    end
`endif

    // Pending write on ch1 is discarded by a mid-period reset.
    wait_tick(1, 8, found);
    chk("pre-reset ch1 tick found", found, 1);
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1;
    step(); cfg_wr = 1'b0;
    chk("pre-reset pending", cfg_pending, 4'h2);
    #2 rst = 1'b1;
    #1;
    chk("async reset tick", tick, 4'h0);
    chk("async reset clk_out", clk_out, 4'h0);
    chk("async reset pending", cfg_pending, 4'h0);
`ifdef CLK_DIV_DUTY_EN
    chk("async reset pwm", pwm_out, 4'h0);
    chk("async reset dut5 pwm", pwm5, 5'h00);
`endif
    repeat (3) step();
    rst = 1'b0;
    wait_tick(1, 20, found);
    chk("post-reset tick found", found, 1);
    chk("post-reset all ticks aligned", tick, 4'hF);
    chk("post-reset pending", cfg_pending, 4'h0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("post-reset ch1 period cycle %0d", j), tick[1], (j == 4) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 27: counter and divide-value width.
REQ-003 Parameter DEF_DIV, default 49_999_999: reset terminal count (1 Hz toggle from 100 MHz).
REQ-004 clk_in  input  1  sole clock, 100 MHz nominal.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ch_en  input  NUM_CH  per-channel run enable.
REQ-007 cfg_wr  input  1  single-cycle write strobe for the divide value.
REQ-008 cfg_ch  input  CH_W = max(1, clog2(NUM_CH))  target channel of the write.
REQ-009 cfg_div  input  CNT_W  new terminal count.
REQ-010 cfg_duty  input  CNT_W  new duty compare value; present only with CLK_DIV_DUTY_EN.
REQ-011 tick  output  NUM_CH  one-cycle pulse at each terminal count.
REQ-012 clk_out  output  NUM_CH  divided clock, toggles on each tick.
REQ-013 cfg_pending  output  NUM_CH  written value is waiting in the shadow register.
REQ-014 pwm_out  output  NUM_CH  duty-controlled output; present only with CLK_DIV_DUTY_EN.

Function
REQ-015 Each channel SHALL hold a CNT_W counter, an active divide register (act_div) and a shadow divide register (shd_div).
REQ-016 While ch_en[i]=1, the counter SHALL increment each cycle and wrap to 0 on the cycle it equals act_div.
REQ-017 tick[i] SHALL be registered and high for exactly the one cycle following the cycle where count==act_div; period = act_div+1 cycles.
REQ-018 clk_out[i] SHALL toggle in the same cycle tick[i] rises; its period = 2*(act_div+1) cycles.
REQ-019 act_div=0 SHALL give tick held high continuously and clk_out toggling every cycle.
REQ-020 cfg_wr with cfg_ch<NUM_CH SHALL load shd_div and set cfg_pending[cfg_ch] on the next edge.
REQ-021 Writes with cfg_ch>=NUM_CH SHALL be ignored, with no state change.
REQ-022 At a terminal count with cfg_pending[i]=1, act_div SHALL load shd_div, the counter SHALL restart at 0 and cfg_pending[i] SHALL clear; the running period is never truncated.
REQ-023 A write on the same cycle as the terminal count SHALL apply at that terminal count, and cfg_pending SHALL stay 0.
REQ-024 A second write while pending SHALL overwrite shd_div; last write wins.
REQ-025 While ch_en[i]=0: counter=0, tick[i]=0, clk_out[i]=0, and a pending shadow SHALL be applied within one cycle, clearing cfg_pending[i].
REQ-026 On a 0->1 edge of ch_en[i], the first tick SHALL occur act_div+1 cycles later.
REQ-027 Channels SHALL be fully independent; simultaneous ticks on all channels SHALL be legal.

Reset
REQ-028 Asserting rst SHALL immediately set counters=0, act_div=shd_div=DEF_DIV, tick=0, clk_out=0, cfg_pending=0 and pwm_out=0.
REQ-029 Reset asserted mid-period SHALL discard pending writes.
REQ-030 Deassertion SHALL be synchronised internally so that all channels leave reset on the same clk_in edge.

Configuration
REQ-031 Macro CLK_DIV_DUTY_EN SHALL control the duty feature.
REQ-032 With CLK_DIV_DUTY_EN defined: cfg_duty and pwm_out exist; cfg_duty is shadowed and applied exactly like cfg_div; pwm_out[i]=1 while count<act_duty, registered, 1-cycle latency; act_duty>act_div gives constant 1; act_duty=0 gives constant 0; reset value of act_duty is (DEF_DIV+1)/2.
REQ-033 Without CLK_DIV_DUTY_EN: cfg_duty, pwm_out and all duty logic are absent; all other behaviour is identical.

Structure
REQ-034 Package clk_div_pkg SHALL hold the default constants (NUM_CH, CNT_W, DEF_DIV) and the CH_W width function.
REQ-035 Sub-module clk_div_ch SHALL implement one channel and be instantiated NUM_CH times via generate.
REQ-036 The top level SHALL contain only reset synchronisation and write decode.

Verification (NUM_CH=4, CNT_W=8, DEF_DIV=3)
REQ-037 Bench: reset released, all ch_en=1 -> tick every 4 cycles and clk_out period 8 on all channels.
REQ-038 Bench: write div=1 to ch2 mid-period -> cfg_pending[2]=1 until the current period completes, then tick every 2 cycles; other channels unchanged.
REQ-039 Bench: write div=0 coincident with ch0 terminal count -> cfg_pending[0] never asserts, and tick[0] is constant high from the next cycle.
REQ-040 Bench: write cfg_ch=5 -> no output or pending change; writes 7 then 2 to ch1 while pending -> ch1 applies 2.
REQ-041 Bench: ch_en[3] dropped mid-count, then raised -> outputs 0 while low; first tick 4 cycles after the rise.
REQ-042 Bench (CLK_DIV_DUTY_EN): duty=1 with div=3 -> pwm_out high 1 of every 4 cycles; duty=9 -> constant 1; rst pulse mid-test -> all outputs 0 immediately.
